// File: rtl/sdp_wdma_req_gen.sv
`timescale 1ns/1ps
// SDP WDMA request generator: splits each line of an output surface into aligned
// DMA write bursts (command followed by its data beats) and pulses op_done at surface end.
module sdp_wdma_req_gen #(
    parameter int DW        = 256,
    parameter int AW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          op_load,
    input  logic [AW-1:0] cfg_base_addr,
    input  logic [AW-1:0] cfg_line_stride,
    input  logic [12:0]   cfg_width,
    input  logic [12:0]   cfg_height,
    input  logic          inp_pvld,
    output logic          inp_prdy,
    input  logic [DW-1:0] inp_data,
    output logic          dma_wr_req_pvld,
    input  logic          dma_wr_req_prdy,
    output logic          dma_wr_req_type,
    output logic [AW-1:0] dma_wr_req_addr,
    output logic [3:0]    dma_wr_req_size,
    output logic [DW-1:0] dma_wr_req_data,
    output logic          op_busy,
    output logic          op_done
);

    localparam int LB = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] line_addr, cur_addr, stride_q;
    logic [12:0]   width_q, lines_left;
    logic [13:0]   beats_left, beats_rem;
    logic [3:0]    beat_cnt;
    logic [4:0]    room, burst_len;
    logic [AW-1:0] cur_addr_inc, line_addr_nxt, base_aligned;
    logic          load, cmd_fire, beat_fire, last_beat;

    // Beats left before the next MAX_BURST*32-byte boundary caps the burst.
    assign room          = 5'(MAX_BURST) - 5'(cur_addr[5+LB-1:5]);
    assign burst_len     = (beats_left < 14'(room)) ? beats_left[4:0] : room;
    assign beats_rem     = beats_left - 14'(burst_len);
    assign cur_addr_inc  = cur_addr + AW'({burst_len, 5'b0});
    assign line_addr_nxt = line_addr + stride_q;
    assign base_aligned  = cfg_base_addr & ~AW'(31);

    assign load      = (state == IDLE) && op_load;
    assign cmd_fire  = (state == CMD) && dma_wr_req_prdy;
    assign beat_fire = (state == DATA) && inp_pvld && dma_wr_req_prdy;
    assign last_beat = beat_fire && (beat_cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        inp_prdy        = 1'b0;
        dma_wr_req_pvld = 1'b0;
        dma_wr_req_type = 1'b0;
        dma_wr_req_addr = '0;
        dma_wr_req_size = 4'd0;
        dma_wr_req_data = '0;
        op_done         = 1'b0;
        op_busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (op_load) state_nxt = CMD;
            end
            CMD: begin
                dma_wr_req_pvld = 1'b1;
                dma_wr_req_addr = cur_addr;
                dma_wr_req_size = 4'(burst_len - 5'd1);
                if (dma_wr_req_prdy) state_nxt = DATA;
            end
            DATA: begin
                dma_wr_req_pvld = inp_pvld;
                inp_prdy        = dma_wr_req_prdy;
                dma_wr_req_type = 1'b1;
                dma_wr_req_data = inp_data;
                if (last_beat) begin
                    if (beats_rem != 14'd0 || lines_left != 13'd0) state_nxt = CMD;
                    else                                           state_nxt = DONE;
                end
            end
            DONE: begin
                op_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            line_addr  <= '0;
            cur_addr   <= '0;
            stride_q   <= '0;
            width_q    <= '0;
            lines_left <= '0;
            beats_left <= '0;
            beat_cnt   <= '0;
        end else if (load) begin
            line_addr  <= base_aligned;
            cur_addr   <= base_aligned;
            stride_q   <= cfg_line_stride & ~AW'(31);
            width_q    <= cfg_width;
            lines_left <= cfg_height;
            beats_left <= {1'b0, cfg_width} + 14'd1;
        end else if (cmd_fire) begin
            beat_cnt <= 4'(burst_len - 5'd1);
        end else if (beat_fire) begin
            if (!last_beat) begin
                beat_cnt <= beat_cnt - 4'd1;
            end else if (beats_rem != 14'd0 || lines_left == 13'd0) begin
                cur_addr   <= cur_addr_inc;
                beats_left <= beats_rem;
            end else begin
                // Line finished with more lines to go: restart at the next line start.
                lines_left <= lines_left - 13'd1;
                line_addr  <= line_addr_nxt;
                cur_addr   <= line_addr_nxt;
                beats_left <= {1'b0, width_q} + 14'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdp_wdma_req_gen.sv
`timescale 1ns/1ps
// Randomized self-checking bench for sdp_wdma_req_gen: an expected request list is
// built from the surface geometry and compared against the DMA bus every cycle.
module tb_sdp_wdma_req_gen;

    logic         nvdla_core_clk = 1'b0;
    logic         nvdla_core_rstn = 1'b0;
    logic         op_load = 1'b0;
    logic [31:0]  cfg_base_addr = '0, cfg_line_stride = '0;
    logic [12:0]  cfg_width = '0, cfg_height = '0;
    logic         inp_pvld = 1'b0, inp_prdy;
    logic [255:0] inp_data = '0;
    logic         dma_wr_req_pvld, dma_wr_req_prdy = 1'b0, dma_wr_req_type;
    logic [31:0]  dma_wr_req_addr;
    logic [3:0]   dma_wr_req_size;
    logic [255:0] dma_wr_req_data;
    logic         op_busy, op_done;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    sdp_wdma_req_gen dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .op_load        (op_load),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_line_stride(cfg_line_stride),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy),
        .inp_data       (inp_data),
        .dma_wr_req_pvld(dma_wr_req_pvld),
        .dma_wr_req_prdy(dma_wr_req_prdy),
        .dma_wr_req_type(dma_wr_req_type),
        .dma_wr_req_addr(dma_wr_req_addr),
        .dma_wr_req_size(dma_wr_req_size),
        .dma_wr_req_data(dma_wr_req_data),
        .op_busy        (op_busy),
        .op_done        (op_done)
    );

    typedef struct {
        logic         typ;
        logic [31:0]  addr;
        logic [3:0]   size;
        logic [255:0] data;
    } item_t;

    item_t        exp_q[$];
    logic [255:0] src_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected bus traffic: each line is cut at 256-byte boundaries (8 beats of 32 B).
    task automatic build_exp(input logic [31:0] base, input logic [31:0] stride,
                             input int width, input int height);
        item_t       it;
        logic [31:0] addr;
        int          beats, room, n;
        exp_q.delete();
        src_q.delete();
        for (int l = 0; l <= height; l++) begin
            addr  = (base & 32'hFFFF_FFE0) + 32'(l) * (stride & 32'hFFFF_FFE0);
            beats = width + 1;
            while (beats > 0) begin
                room = 8 - int'((addr >> 5) & 32'd7);
                n    = (beats < room) ? beats : room;
                it.typ = 1'b0; it.addr = addr; it.size = 4'(n - 1); it.data = '0;
                exp_q.push_back(it);
                for (int k = 0; k < n; k++) begin
                    it.typ = 1'b1; it.addr = '0; it.size = '0; it.data = rand_beat();
                    src_q.push_back(it.data);
                    exp_q.push_back(it);
                end
                addr  = addr + 32'(n * 32);
                beats = beats - n;
            end
        end
    endtask

    task automatic run_surface(input logic [31:0] base, input logic [31:0] stride,
                               input int width, input int height,
                               input int prdy_pct, input int pvld_pct,
                               input bit load_mid, input int abort_after);
        item_t        it;
        bit           stall = 0, inp_hs = 0, mid_done = 0, timed_out = 0;
        int           hs_cnt = 0, cyc = 0;
        logic         p_pvld, p_type;
        logic [31:0]  p_addr;
        logic [3:0]   p_size;
        logic [255:0] p_data;
        build_exp(base, stride, width, height);
        @(negedge nvdla_core_clk);
        check("idle_busy", op_busy, 1'b0);
        check("idle_pvld", dma_wr_req_pvld, 1'b0);
        check("idle_inp_prdy", inp_prdy, 1'b0);
        @(posedge nvdla_core_clk); #1;
        cfg_base_addr = base; cfg_line_stride = stride;
        cfg_width = 13'(width); cfg_height = 13'(height);
        op_load = 1'b1;
        dma_wr_req_prdy = ($urandom_range(99) < prdy_pct);
        inp_pvld = ($urandom_range(99) < pvld_pct);
        inp_data = src_q[0];
        @(posedge nvdla_core_clk); #1;
        op_load = 1'b0;
        cfg_base_addr = $urandom; cfg_line_stride = $urandom;
        cfg_width = 13'($urandom); cfg_height = 13'($urandom);
        while (exp_q.size() > 0) begin
            @(negedge nvdla_core_clk);
            cyc++;
            if (cyc > 3000) begin
                check("timeout", 1'b1, 1'b0);
                timed_out = 1;
                break;
            end
            check("busy", op_busy, 1'b1);
            check("done_early", op_done, 1'b0);
            if (stall) begin
                check("stall_pvld", dma_wr_req_pvld, p_pvld);
                check("stall_type", dma_wr_req_type, p_type);
                check("stall_addr", dma_wr_req_addr, p_addr);
                check("stall_size", dma_wr_req_size, p_size);
                check("stall_data", dma_wr_req_data, p_data);
            end
            if (exp_q[0].typ == 1'b0) begin
                check("cmd_pvld", dma_wr_req_pvld, 1'b1);
                check("cmd_inp_prdy", inp_prdy, 1'b0);
            end else begin
                check("data_pvld", dma_wr_req_pvld, inp_pvld);
                check("data_inp_prdy", inp_prdy, dma_wr_req_prdy);
            end
            inp_hs = inp_pvld && inp_prdy;
            if (dma_wr_req_pvld && dma_wr_req_prdy) begin
                it = exp_q.pop_front();
                check("req_type", dma_wr_req_type, it.typ);
                check("req_addr", dma_wr_req_addr, it.addr);
                check("req_size", dma_wr_req_size, it.size);
                check("req_data", dma_wr_req_data, it.data);
                hs_cnt++;
            end
            stall  = dma_wr_req_pvld && !dma_wr_req_prdy;
            p_pvld = dma_wr_req_pvld; p_type = dma_wr_req_type; p_addr = dma_wr_req_addr;
            p_size = dma_wr_req_size; p_data = dma_wr_req_data;
            if (abort_after > 0 && hs_cnt >= abort_after) return;
            @(posedge nvdla_core_clk); #1;
            if (inp_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (!(inp_pvld && !inp_hs))
                inp_pvld = (src_q.size() > 0) && ($urandom_range(99) < pvld_pct);
            inp_data = (src_q.size() > 0) ? src_q[0] : rand_beat();
            dma_wr_req_prdy = ($urandom_range(99) < prdy_pct);
            op_load = 1'b0;
            if (load_mid && !mid_done && exp_q.size() > 4 && exp_q[0].typ == 1'b1) begin
                op_load = 1'b1;
                mid_done = 1;
                cfg_base_addr = 32'h0000_4000; cfg_width = 13'd0; cfg_height = 13'd0;
            end
        end
        if (timed_out) return;
        @(negedge nvdla_core_clk);
        check("done_pulse", op_done, 1'b1);
        check("done_busy", op_busy, 1'b1);
        check("done_pvld", dma_wr_req_pvld, 1'b0);
        check("done_inp_prdy", inp_prdy, 1'b0);
        check("src_consumed", 32'(src_q.size()), 32'd0);
        inp_pvld = 1'b0;
        @(negedge nvdla_core_clk);
        check("after_done", op_done, 1'b0);
        check("after_busy", op_busy, 1'b0);
        check("after_inp_prdy", inp_prdy, 1'b0);
    endtask

    task automatic pin_cmds(input string tag, input logic [31:0] a[$], input logic [3:0] s[$]);
        int c = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].typ == 1'b0) begin
                if (c < a.size()) begin
                    check({tag, "_addr"}, exp_q[i].addr, a[c]);
                    check({tag, "_size"}, exp_q[i].size, s[c]);
                end
                c++;
            end
        end
        check({tag, "_ncmd"}, 32'(c), 32'(a.size()));
    endtask

    initial begin
        #12;
        check("rst_pvld", dma_wr_req_pvld, 1'b0);
        check("rst_type", dma_wr_req_type, 1'b0);
        check("rst_addr", dma_wr_req_addr, 32'd0);
        check("rst_size", dma_wr_req_size, 4'd0);
        check("rst_data", dma_wr_req_data, 256'd0);
        check("rst_inp_prdy", inp_prdy, 1'b0);
        check("rst_busy", op_busy, 1'b0);
        check("rst_done", op_done, 1'b0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;

        build_exp(32'h1000, 32'h100, 3, 1);
        pin_cmds("pin_aligned", '{32'h1000, 32'h1100}, '{4'd3, 4'd3});
        build_exp(32'h10C0, 32'h0, 9, 0);
        pin_cmds("pin_split", '{32'h10C0, 32'h1100}, '{4'd1, 4'd7});
        build_exp(32'hFFFF_FFE0, 32'h0, 19, 0);
        pin_cmds("pin_wrap", '{32'hFFFF_FFE0, 32'h0, 32'h100, 32'h200},
                 '{4'd0, 4'd7, 4'd7, 4'd2});

        run_surface(32'h1000, 32'h100, 3, 1, 100, 100, 0, 0);
        run_surface(32'h10C0, 32'h0, 9, 0, 100, 100, 0, 0);
        run_surface(32'h1000, 32'h100, 3, 1, 50, 50, 0, 0);
        run_surface(32'h0000_0020, 32'h0, 0, 0, 100, 100, 0, 0);
        run_surface(32'hFFFF_FFE0, 32'h0, 19, 0, 70, 80, 0, 0);
        run_surface(32'h1000, 32'h100, 3, 1, 100, 100, 1, 0);

        for (int r = 0; r < 6; r++)
            run_surface($urandom, $urandom, int'($urandom_range(20)), int'($urandom_range(3)),
                        int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 0);

        // Abandon a surface mid-burst; reset must clear outputs at once.
        run_surface(32'h1000, 32'h100, 3, 1, 100, 100, 0, 3);
        @(posedge nvdla_core_clk); #2;
        nvdla_core_rstn = 1'b0;
        inp_pvld = 1'b0;
        #1;
        check("mid_rst_pvld", dma_wr_req_pvld, 1'b0);
        check("mid_rst_type", dma_wr_req_type, 1'b0);
        check("mid_rst_data", dma_wr_req_data, 256'd0);
        check("mid_rst_inp_prdy", inp_prdy, 1'b0);
        check("mid_rst_busy", op_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge nvdla_core_clk);
            check("mid_rst_done", op_done, 1'b0);
        end
        nvdla_core_rstn = 1'b1;
        run_surface(32'h0000_2040, 32'h300, 5, 2, 60, 70, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_wdma_req_gen.md
# sdp_wdma_req_gen

Downstream neighbour of the SDP WDMA pack stage. It takes packed DW-bit write beats and turns them into DMA write requests for one output surface. Each request is a command (address and beat count) followed by that many data beats. Lines are split into aligned bursts, and the block advances by a line stride per line and pulses done at surface end.

## Interface
Parameters:
- DW, 256, data beat width in bits; one beat = 32 bytes (DW=256 fixed for address math)
- AW, 32, byte address width
- MAX_BURST, 8, maximum beats per command; power of two, 2..16

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset; asynchronous, active-low
- op_load  in  1  single-cycle start pulse; sampled only in IDLE
- cfg_base_addr  in  AW  surface start byte address; bits [4:0] ignored
- cfg_line_stride  in  AW  byte distance between line starts; bits [4:0] ignored
- cfg_width  in  13  beats per line minus one
- cfg_height  in  13  lines minus one
- inp_pvld  in  1  packed beat valid
- inp_prdy  out  1  packed beat ready
- inp_data  in  DW  packed beat
- dma_wr_req_pvld  out  1  request valid
- dma_wr_req_prdy  in  1  request ready
- dma_wr_req_type  out  1  0 = command, 1 = data
- dma_wr_req_addr  out  AW  command byte address (32B aligned), 0 when type=1
- dma_wr_req_size  out  4  command beats minus one, 0 when type=1
- dma_wr_req_data  out  DW  data beat (equals inp_data when type=1, else 0)
- op_busy  out  1  high from accepted op_load until done
- op_done  out  1  single-cycle pulse at surface completion

## Operation
- The FSM has four states: IDLE, CMD, DATA, DONE.
- **IDLE:** on op_load, latch all cfg_*. Set line_addr = cur_addr = base & ~31, beats_left = cfg_width+1, and lines_left = cfg_height. Go to CMD.
- **Burst length:** burst_len = min(MAX_BURST - cur_addr[5+log2(MAX_BURST)-1:5], beats_left). Bursts therefore never cross a MAX_BURST*32-byte aligned boundary. burst_len is computed combinationally from registers.
- **CMD:**
  - dma_wr_req_pvld=1, type=0, addr=cur_addr, size=burst_len-1.
  - inp_prdy=0.
  - On handshake: beat_cnt=burst_len-1; go to DATA.
- **DATA:**
  - Pass-through: dma_wr_req_pvld=inp_pvld, inp_prdy=dma_wr_req_prdy, type=1, data=inp_data.
  - Each accepted beat decrements beat_cnt.
  - On the last beat of the burst: cur_addr += burst_len*32 and beats_left -= burst_len.
    - If beats_left becomes nonzero, go to CMD.
    - Else if lines_left != 0: lines_left -= 1, line_addr += stride, cur_addr = line_addr+stride, beats_left = cfg_width+1; go to CMD.
    - Else go to DONE.
- **DONE:** op_done=1 for one cycle, then go to IDLE.
- **op_busy:** 1 in CMD, DATA and DONE; 0 in IDLE.
- **Address arithmetic:** modulo 2^AW, so wrap-around is silent.
- **Unused input:** input beats beyond the surface total are not accepted (inp_prdy=0 outside DATA).
- **Ignored op_load:** op_load in any state other than IDLE is ignored, and cfg changes while busy have no effect.

## Timing
- **Reset values:**
  - State = IDLE.
  - dma_wr_req_pvld, type, addr, size, data = 0.
  - inp_prdy=0, op_busy=0, op_done=0.
  - All counters and address registers = 0.
- **Start latency:** op_load at cycle N puts the command on the bus at N+1; op_busy rises at N+1.
- **Command accept latency:** the command is accepted at the edge where pvld&prdy=1. The first data beat can then be accepted in the next cycle.
- **Data latency:** zero cycles. Data beats combinationally follow inp_*; back-to-back beats sustain one per cycle.
- **Command overhead:** each command costs at least one cycle with no data transfer.
- **Stall:** prdy low holds all outputs stable and holds state.
- **Done latency:** op_done is asserted the cycle after the final data beat handshake. A new op_load is accepted in the cycle after op_done, when state is IDLE.
- **Reset mid-operation:** outputs return to reset values immediately (async). Any partial surface is abandoned and no op_done is issued.

## Test plan
- **Aligned surface:** MAX_BURST=8, base 0x1000, stride 0x100, width=3, height=1 with continuous data.
  - Required: cmd(0x1000, size 3), 4 data beats, cmd(0x1100, size 3), 4 data beats.
  - op_done pulses one cycle after the 8th beat; op_busy is then deasserted.
- **Misaligned split:** base 0x10C0, width=9, height=0.
  - Required: cmd(0x10C0, size 1), 2 beats, cmd(0x1100, size 7), 8 beats, done.
- **Backpressure:** random dma_wr_req_prdy (50%) and random inp_pvld on the aligned case.
  - Required: identical request sequence with data order preserved and no beats lost or duplicated.
  - Outputs are stable while pvld=1 and prdy=0.
- **Minimum surface:** width=0, height=0, base 0x20.
  - Required: cmd(0x20, size 0), 1 beat, op_done.
  - inp_prdy stays 0 before the command is accepted and after the beat.
- **Long line and wrap:** width=19 at base 0xFFFFFFE0.
  - Required: bursts of 1, 8, 8 and 3 beats at 0xFFFFFFE0, 0x0, 0x100 and 0x200.
- **Control corner cases:**
  - op_load pulsed during DATA: ignored, and the original surface completes.
  - Reset asserted mid-burst: all outputs are 0 at once and no op_done.
  - After reset, op_load starts a fresh surface from the new cfg values.
